// File: rtl/qpsk_frame_ctrl.sv
// ---------------------------------------------------------------------------
// qpsk_frame_ctrl
//
// Serial frame generator feeding the QPSK I/Q splitter. A frame is:
//   PREAMBLE_BITS alternating bits (1,0,1,0,...)
//   SYNC_WORD, 8 bits, MSB first
//   FRAME_BYTES payload bytes, each MSB first, pulled through a one-byte
//   holding buffer with a valid/ready handshake
//   GAP_BITS zero bits
// Every bit is held for BIT_CLKS clock cycles. If no payload byte is
// available when one is needed, the frame is cut short: it goes straight to
// the gap and raises the sticky underrun flag.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   start      in   frame request, only looked at while idle
//   tx_data    in   [7:0] payload byte
//   tx_valid   in   payload byte offered
//   tx_ready   out  payload byte accepted this cycle when tx_valid is high
//   ser_o      out  serial bit stream
//   bit_stb    out  high on the first cycle of every transmitted bit
//   busy       out  high whenever a frame is in progress
//   frame_done out  one-cycle pulse on the first idle cycle after a frame
//   underrun   out  sticky: last frame ran out of payload data
// ---------------------------------------------------------------------------
module qpsk_frame_ctrl #(
  parameter int         BIT_CLKS      = 10000,
  parameter int         PREAMBLE_BITS = 16,
  parameter logic [7:0] SYNC_WORD     = 8'hD3,
  parameter int         FRAME_BYTES   = 4,
  parameter int         GAP_BITS      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ser_o,
  output logic       bit_stb,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  // Bit-phase counter width (at least one bit even for BIT_CLKS == 1).
  localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

  // One bit-index counter is shared by preamble, sync, payload and gap, so it
  // must reach the longest of the three field lengths.
  localparam int MAXB_A = (PREAMBLE_BITS > GAP_BITS) ? PREAMBLE_BITS : GAP_BITS;
  localparam int MAXB   = (MAXB_A > 8) ? MAXB_A : 8;
  localparam int BW     = $clog2(MAXB);

  localparam logic [CW-1:0] PH_LAST   = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] PH_ONE    = CW'(1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] PRE_LAST  = BW'(PREAMBLE_BITS - 1);
  localparam logic [BW-1:0] GAP_LAST  = BW'(GAP_BITS - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(7);
  localparam logic [7:0]    LAST_BYTE = 8'(FRAME_BYTES - 1);
  localparam logic [7:0]    NUM_BYTES = 8'(FRAME_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SYNC,
    S_PAYLOAD,
    S_GAP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_phase;      // cycle within the current bit
  logic [BW-1:0] r_bit_idx;    // bit within the current field / byte
  logic [7:0]    r_byte_idx;   // payload byte currently on the line
  logic [6:0]    r_shift;      // bits of the current byte still to send
  logic          r_ser;
  logic [7:0]    r_buf;        // holding buffer
  logic          r_buf_full;
  logic [7:0]    r_fetched;    // bytes accepted so far this frame
  logic          r_done;
  logic          r_underrun;

  logic       w_boundary;
  logic       w_ready;
  logic       w_accept;
  logic       w_byte_start;
  logic       w_have_byte;
  logic [7:0] w_next_byte;

  assign w_boundary = (r_phase == PH_LAST);

  assign w_ready = ((r_state == S_SYNC) || (r_state == S_PAYLOAD)) &&
                   !r_buf_full && (r_fetched < NUM_BYTES);

  assign w_accept = w_ready && tx_valid;

  // Last cycle of the sync word, or of a payload byte that is not the final
  // one: the next payload byte has to be on hand right now.
  assign w_byte_start = w_boundary && (r_bit_idx == BYTE_LAST) &&
                        ((r_state == S_SYNC) ||
                         ((r_state == S_PAYLOAD) && (r_byte_idx != LAST_BYTE)));

  // A byte arriving in the load cycle itself goes straight to the shifter,
  // so data offered as late as the final cycle of the previous byte still
  // makes it into the frame.
  assign w_have_byte = r_buf_full || w_accept;
  assign w_next_byte = r_buf_full ? r_buf : tx_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_ser      <= 1'b0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_fetched  <= '0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Holding buffer: a load empties it, an accept that is not consumed by
      // a load in the same cycle fills it.
      if (w_byte_start && w_have_byte) begin
        r_buf_full <= 1'b0;
      end else if (w_accept) begin
        r_buf_full <= 1'b1;
      end
      if (w_accept) begin
        r_buf     <= tx_data;
        r_fetched <= r_fetched + 8'd1;
      end

      if (r_state == S_IDLE) begin
        r_phase <= '0;
      end else if (w_boundary) begin
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + PH_ONE;
      end

      case (r_state)
        S_IDLE: begin
          r_ser <= 1'b0;
          if (start) begin
            r_state    <= S_PREAMBLE;
            r_ser      <= 1'b1;
            r_bit_idx  <= '0;
            r_fetched  <= '0;
            r_buf_full <= 1'b0;
            r_underrun <= 1'b0;
          end
        end

        S_PREAMBLE: begin
          if (w_boundary) begin
            if (r_bit_idx == PRE_LAST) begin
              r_state   <= S_SYNC;
              r_bit_idx <= '0;
              r_ser     <= SYNC_WORD[7];
              r_shift   <= SYNC_WORD[6:0];
            end else begin
              r_bit_idx <= r_bit_idx + BIT_ONE;
              // Even-numbered bits are 1, so the next bit is the LSB of the
              // current index.
              r_ser     <= r_bit_idx[0];
            end
          end
        end

        S_SYNC, S_PAYLOAD: begin
          if (w_boundary) begin
            if (r_bit_idx != BYTE_LAST) begin
              r_bit_idx <= r_bit_idx + BIT_ONE;
              r_ser     <= r_shift[6];
              r_shift   <= {r_shift[5:0], 1'b0};
            end else if (w_byte_start) begin
              r_bit_idx <= '0;
              if (w_have_byte) begin
                r_state    <= S_PAYLOAD;
                r_ser      <= w_next_byte[7];
                r_shift    <= w_next_byte[6:0];
                r_byte_idx <= (r_state == S_SYNC) ? 8'd0 : r_byte_idx + 8'd1;
              end else begin
                // Nothing to send: cut the frame short but keep the gap so
                // the frame still ends on a clean zero tail.
                r_state    <= S_GAP;
                r_ser      <= 1'b0;
                r_underrun <= 1'b1;
              end
            end else begin
              r_state   <= S_GAP;
              r_bit_idx <= '0;
              r_ser     <= 1'b0;
            end
          end
        end

        S_GAP: begin
          r_ser <= 1'b0;
          if (w_boundary) begin
            if (r_bit_idx == GAP_LAST) begin
              r_state   <= S_IDLE;
              r_bit_idx <= '0;
              r_done    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + BIT_ONE;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_ser   <= 1'b0;
        end
      endcase
    end
  end

  // Plain decodes of registered state; no combinational input paths except
  // tx_ready, whose value depends only on registers.
  assign tx_ready   = w_ready;
  assign ser_o      = r_ser;
  assign bit_stb    = (r_state != S_IDLE) && (r_phase == '0);
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_done;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_qpsk_frame_ctrl.sv
`timescale 1ns/1ps
module tb_qpsk_frame_ctrl;

  localparam int         BC = 4;
  localparam int         PB = 4;
  localparam int         FB = 2;
  localparam int         GB = 2;
  localparam logic [7:0] SW = 8'hD3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ser_o, bit_stb, busy, frame_done, underrun;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  qpsk_frame_ctrl #(
    .BIT_CLKS(BC), .PREAMBLE_BITS(PB), .SYNC_WORD(SW),
    .FRAME_BYTES(FB), .GAP_BITS(GB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ser_o(ser_o), .bit_stb(bit_stb), .busy(busy),
    .frame_done(frame_done), .underrun(underrun)
  );

  // ---------------- behavioural model: frame timeline in cycles ----------
  bit         m_active = 0;
  bit         m_done = 0;
  bit         m_underrun = 0;
  bit         m_buf_full = 0;
  int         m_t = 0;
  int         m_fetched = 0;
  int         m_gap_start = PB + 8 + 8 * FB;
  logic [7:0] m_buf = 8'h00;
  logic [7:0] m_bytes [FB];

  function automatic bit model_ready();
    int b;
    if (!m_active) return 1'b0;
    b = m_t / BC;
    return (b >= PB) && (b < m_gap_start) && !m_buf_full && (m_fetched < FB);
  endfunction

  function automatic logic exp_ser();
    int b, k, j;
    logic [7:0] v;
    if (!m_active) return 1'b0;
    b = m_t / BC;
    if (b < PB) return ((b % 2) == 0);
    if (b < PB + 8) begin
      v = SW;
      return v[7 - (b - PB)];
    end
    if (b < m_gap_start) begin
      k = (b - PB - 8) / 8;
      j = (b - PB - 8) % 8;
      v = m_bytes[k];
      return v[7 - j];
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    int b, k;
    bit acc, bnd;
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_underrun = 0; m_buf_full = 0;
      m_t = 0; m_fetched = 0;
      return;
    end
    if (!m_active) begin
      m_done = 0;
      if (start) begin
        m_active = 1; m_t = 0; m_underrun = 0; m_buf_full = 0;
        m_fetched = 0; m_gap_start = PB + 8 + 8 * FB;
      end
      return;
    end
    b = m_t / BC;
    acc = model_ready() && tx_valid;
    if (acc) m_fetched++;
    // Last cycle before a payload byte begins?
    bnd = ((m_t % BC) == BC - 1) && (b + 1 >= PB + 8) && (b + 1 < m_gap_start) &&
          (((b + 1 - PB - 8) % 8) == 0);
    if (bnd) begin
      k = (b + 1 - PB - 8) / 8;
      if (m_buf_full) begin
        m_bytes[k] = m_buf;
        m_buf_full = 0;
      end else if (acc) begin
        m_bytes[k] = tx_data;
        acc = 0;
      end else begin
        m_underrun = 1;
        m_gap_start = b + 1;
      end
    end
    if (acc) begin
      m_buf = tx_data;
      m_buf_full = 1;
    end
    m_t++;
    if (m_t == (m_gap_start + GB) * BC) begin
      m_active = 0;
      m_done = 1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // ---------------- checking ---------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("ser_o", 32'(ser_o), 32'(exp_ser()));
    chk("busy", 32'(busy), 32'(m_active));
    chk("bit_stb", 32'(bit_stb), 32'(m_active && ((m_t % BC) == 0)));
    chk("tx_ready", 32'(tx_ready), 32'(model_ready()));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("underrun", 32'(underrun), 32'(m_underrun));
  end

  // Observe a frame from the cycle after the edge that sampled start (n=0).
  task automatic capture(input int ncyc, output logic [29:0] bits, output int done_n,
                         output int stb_cnt, output int busy_cnt, output int bad_stb,
                         output logic und_at_done, output logic post_busy,
                         output logic post_und);
    logic prev_ser;
    prev_ser = ser_o;
    bits = '0; done_n = -1; stb_cnt = 0; busy_cnt = 0; bad_stb = 0;
    und_at_done = 1'b0; post_busy = 1'b0; post_und = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      if (n < 120 && (n % 4) == 0) bits[29 - n / 4] = ser_o;
      if (bit_stb) stb_cnt++;
      if (busy) busy_cnt++;
      if (ser_o !== prev_ser && !bit_stb) bad_stb++;
      prev_ser = ser_o;
      if (done_n >= 0 && n == done_n + 1) begin
        post_busy = busy;
        post_und = underrun;
      end
      if (frame_done && done_n < 0) begin
        done_n = n;
        und_at_done = underrun;
      end
    end
  endtask

  // Leaves the time at the start-sampling edge + 1.
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (k >= 500) begin
      fails++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, k);
    end
  endtask

  logic [29:0] cb, exp_bits;
  int          dn, sc, bcnt, bs, p;
  logic        ud, pb, pu;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ser_o", 32'(ser_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_ready", 32'(tx_ready), 0);
    chk("rst_bit_stb", 32'(bit_stb), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_underrun", 32'(underrun), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Nominal frame: A5, 3C always valid
    #1 tx_valid = 1'b1; tx_data = 8'hA5;
    pulse_start();
    fork
      capture(125, cb, dn, sc, bcnt, bs, ud, pb, pu);
      begin repeat (30) @(posedge clk); #1 tx_data = 8'h3C; end
    join
    exp_bits = {4'b1010, 8'hD3, 8'hA5, 8'h3C, 2'b00};
    $display("[TB] nominal frame bits=%b done_n=%0d", cb, dn);
    chk("nom_bits", 32'(cb), 32'(exp_bits));
    chk("nom_done_cycle", dn, 120);
    chk("nom_busy_cycles", bcnt, 120);
    chk("nom_stb_count", sc, 30);
    chk("nom_ser_change_off_stb", bs, 0);
    chk("nom_underrun", 32'(ud), 0);

    // Underrun: no data ever offered
    tx_valid = 1'b0;
    pulse_start();
    capture(70, cb, dn, sc, bcnt, bs, ud, pb, pu);
    $display("[TB] underrun frame bits=%b done_n=%0d", cb, dn);
    exp_bits = {4'b1010, 8'hD3, 18'b0};
    chk("und_bits", 32'(cb), 32'(exp_bits));
    chk("und_done_cycle", dn, 56);
    chk("und_busy_cycles", bcnt, 56);
    chk("und_flag", 32'(ud), 1);
    chk("und_stb_count", sc, 14);

    // Late data: first byte offered on the last SYNC cycle
    pulse_start();
    fork
      capture(125, cb, dn, sc, bcnt, bs, ud, pb, pu);
      begin
        repeat (47) @(posedge clk);
        #1 tx_valid = 1'b1; tx_data = 8'h5A;
        @(posedge clk);
        #1 tx_data = 8'h96;
      end
    join
    $display("[TB] late-data frame bits=%b done_n=%0d", cb, dn);
    exp_bits = {4'b1010, 8'hD3, 8'h5A, 8'h96, 2'b00};
    chk("late_bits", 32'(cb), 32'(exp_bits));
    chk("late_done_cycle", dn, 120);
    chk("late_underrun", 32'(ud), 0);

    // Start pulse during PAYLOAD is ignored
    tx_data = 8'h00;
    pulse_start();
    fork
      capture(125, cb, dn, sc, bcnt, bs, ud, pb, pu);
      begin
        repeat (70) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    $display("[TB] start-while-busy frame done_n=%0d busy=%0d", dn, bcnt);
    chk("busy_start_done_cycle", dn, 120);
    chk("busy_start_busy_cycles", bcnt, 120);

    // Start held high through frame_done: underrun frame then immediate restart
    tx_valid = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    capture(60, cb, dn, sc, bcnt, bs, ud, pb, pu);
    $display("[TB] held-start done_n=%0d und=%b next_busy=%b next_und=%b", dn, ud, pb, pu);
    chk("held_done_cycle", dn, 56);
    chk("held_und_at_done", 32'(ud), 1);
    chk("held_restart_busy", 32'(pb), 1);
    chk("held_restart_und_clear", 32'(pu), 0);
    start = 1'b0;
    wait_idle("held_restart_idle");

    // Reset mid-PAYLOAD
    @(posedge clk); #1 tx_valid = 1'b1;
    pulse_start();
    repeat (60) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_ser_o", 32'(ser_o), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_tx_ready", 32'(tx_ready), 0);
    chk("midrst_bit_stb", 32'(bit_stb), 0);
    chk("midrst_frame_done", 32'(frame_done), 0);
    chk("midrst_underrun", 32'(underrun), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    capture(150, cb, dn, sc, bcnt, bs, ud, pb, pu);
    $display("[TB] after mid-frame reset done_n=%0d busy=%0d", dn, bcnt);
    chk("midrst_no_done", dn, -1);
    chk("midrst_idle", bcnt, 0);

    // Randomized traffic checked by the model every cycle
    p = 100;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if ((c % 500) == 0) p = 100 - 15 * (c / 500);
      start = ($urandom_range(0, 99) < 4);
      tx_valid = ($urandom_range(0, 99) < p);
      tx_data = 8'($urandom);
    end
    @(posedge clk); #1 start = 1'b0; tx_valid = 1'b1;
    wait_idle("random_final_idle");
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
